// File: rtl/rv32i_timer_pkg.sv
// rtl/rv32i_timer_pkg.sv - shared constants, types and helpers for the RV32I machine timer
package rv32i_timer_pkg;

  localparam logic [2:0] OFF_MTIME_LO    = 3'd0;
  localparam logic [2:0] OFF_MTIME_HI    = 3'd1;
  localparam logic [2:0] OFF_MTIMECMP_LO = 3'd2;
  localparam logic [2:0] OFF_MTIMECMP_HI = 3'd3;
  localparam logic [2:0] OFF_CTRL        = 3'd4;

  localparam int CTRL_EN_BIT  = 0;
  localparam int CTRL_DIV_LSB = 8;
  localparam int CTRL_DIV_W   = 8;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RESP = 1'b1
  } bus_state_e;

  function automatic logic [31:0] be_merge(input logic [31:0] old_val,
                                           input logic [31:0] new_val,
                                           input logic [3:0]  be);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/rv32i_timer_prescaler.sv
// rtl/rv32i_timer_prescaler.sv - divide-by-(DIV+1) tick generator for mtime
module rv32i_timer_prescaler
  import rv32i_timer_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  en,
  input  logic [CTRL_DIV_W-1:0] div,
  input  logic                  div_wr,
  output logic                  tick
);

  logic [CTRL_DIV_W-1:0] count_q, count_d;

  assign tick = en & (count_q == div);

  always_comb begin
    count_d = count_q + 1'b1;
    if (!en || div_wr || tick) count_d = '0;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) count_q <= '0;
    else          count_q <= count_d;
  end

endmodule

// File: rtl/rv32i_timer.sv
// rtl/rv32i_timer.sv - memory-mapped 64-bit machine timer with compare interrupt and one-wait-state reads
module rv32i_timer
  import rv32i_timer_pkg::*;
#(
  parameter logic [31:0] RV32I_TIMER_BASE      = 32'hF000_0000,
  parameter logic [7:0]  RV32I_TIMER_DIV_RESET = 8'd0
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [31:0] address,
  input  logic        write,
  input  logic [31:0] writedata,
  input  logic [3:0]  byteenable,
  input  logic        read,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic        irq
);

  bus_state_e            state_q, state_d;
  logic [63:0]           mtime_q, mtime_d;
  logic [63:0]           mtimecmp_q, mtimecmp_d;
  logic                  en_q, en_d;
  logic [CTRL_DIV_W-1:0] div_q, div_d;
  logic [31:0]           shadow_q, shadow_d;
  logic [31:0]           readdata_q, readdata_d;
  logic                  irq_q, irq_d;

  logic        sel, wr_en, rd_req, div_wr, tick;
  logic [2:0]  offset;
  logic [31:0] rd_val;
  logic        addr_unused;

  assign addr_unused = ^address[1:0];
  assign sel    = (address[31:5] == RV32I_TIMER_BASE[31:5]);
  assign offset = address[4:2];
  assign wr_en  = write & sel;
  assign rd_req = read & sel & ~write & (state_q == ST_IDLE);
  assign div_wr = wr_en & (offset == OFF_CTRL) & byteenable[1];

  rv32i_timer_prescaler u_prescaler (
    .clk     (clk),
    .reset_n (reset_n),
    .en      (en_q),
    .div     (div_q),
    .div_wr  (div_wr),
    .tick    (tick)
  );

  // A write to either mtime half replaces the tick increment for the whole counter.
  always_comb begin
    mtime_d    = tick ? mtime_q + 64'd1 : mtime_q;
    mtimecmp_d = mtimecmp_q;
    en_d       = en_q;
    div_d      = div_q;
    if (wr_en) begin
      case (offset)
        OFF_MTIME_LO:    mtime_d = {mtime_q[63:32], be_merge(mtime_q[31:0], writedata, byteenable)};
        OFF_MTIME_HI:    mtime_d = {be_merge(mtime_q[63:32], writedata, byteenable), mtime_q[31:0]};
        OFF_MTIMECMP_LO: mtimecmp_d = {mtimecmp_q[63:32], be_merge(mtimecmp_q[31:0], writedata, byteenable)};
        OFF_MTIMECMP_HI: mtimecmp_d = {be_merge(mtimecmp_q[63:32], writedata, byteenable), mtimecmp_q[31:0]};
        OFF_CTRL: begin
          if (byteenable[0]) en_d  = writedata[CTRL_EN_BIT];
          if (byteenable[1]) div_d = writedata[CTRL_DIV_LSB +: CTRL_DIV_W];
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    rd_val = '0;
    case (offset)
      OFF_MTIME_LO:    rd_val = mtime_q[31:0];
      OFF_MTIME_HI:    rd_val = shadow_q;
      OFF_MTIMECMP_LO: rd_val = mtimecmp_q[31:0];
      OFF_MTIMECMP_HI: rd_val = mtimecmp_q[63:32];
      OFF_CTRL:        rd_val = {16'h0, div_q, 7'h0, en_q};
      default:         rd_val = '0;
    endcase
  end

  // readdata_q is only non-zero while in RESP, so it can drive the bus directly.
  always_comb begin
    state_d    = state_q;
    readdata_d = '0;
    shadow_d   = shadow_q;
    case (state_q)
      ST_IDLE: begin
        if (rd_req) begin
          state_d    = ST_RESP;
          readdata_d = rd_val;
          if (offset == OFF_MTIME_LO) shadow_d = mtime_q[63:32];
        end
      end
      ST_RESP: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  assign irq_d = en_q & (mtime_q >= mtimecmp_q);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= ST_IDLE;
      mtime_q    <= '0;
      mtimecmp_q <= '1;
      en_q       <= 1'b0;
      div_q      <= RV32I_TIMER_DIV_RESET;
      shadow_q   <= '0;
      readdata_q <= '0;
      irq_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      mtime_q    <= mtime_d;
      mtimecmp_q <= mtimecmp_d;
      en_q       <= en_d;
      div_q      <= div_d;
      shadow_q   <= shadow_d;
      readdata_q <= readdata_d;
      irq_q      <= irq_d;
    end
  end

  assign readdata    = readdata_q;
  assign waitrequest = rd_req & reset_n;
  assign irq         = irq_q;

endmodule

// File: tb/tb_rv32i_timer.sv
// tb/tb_rv32i_timer.sv - self-checking bench for rv32i_timer against a cycle-level reference model
module tb_rv32i_timer;

  localparam logic [31:0] BASE = 32'hF000_0000;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [31:0] address;
  logic        write;
  logic [31:0] writedata;
  logic [3:0]  byteenable;
  logic        read;
  logic [31:0] readdata;
  logic        waitrequest;
  logic        irq;

  int errors = 0;
  int checks = 0;

  // reference model state
  logic [63:0] m_mtime, m_cmp;
  logic        m_en, m_resp, m_irq;
  logic [7:0]  m_div, m_pc;
  logic [31:0] m_shadow, m_rdata;

  rv32i_timer dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .address     (address),
    .write       (write),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .read        (read),
    .readdata    (readdata),
    .waitrequest (waitrequest),
    .irq         (irq)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] merge(input logic [31:0] o, input logic [31:0] n, input logic [3:0] be);
    logic [31:0] r;
    r = o;
    for (int i = 0; i < 4; i++) if (be[i]) r[8*i +: 8] = n[8*i +: 8];
    return r;
  endfunction

  function automatic logic [31:0] reg_value(input logic [2:0] off);
    case (off)
      3'd0:    return m_mtime[31:0];
      3'd1:    return m_shadow;
      3'd2:    return m_cmp[31:0];
      3'd3:    return m_cmp[63:32];
      3'd4:    return {16'h0, m_div, 7'h0, m_en};
      default: return 32'h0;
    endcase
  endfunction

  task automatic model_reset();
    m_mtime = 64'h0; m_cmp = '1; m_en = 1'b0; m_div = 8'd0; m_pc = 8'd0;
    m_shadow = 32'h0; m_rdata = 32'h0; m_resp = 1'b0; m_irq = 1'b0;
  endtask

  function automatic logic model_sel();
    return address[31:5] == BASE[31:5];
  endfunction

  task automatic model_update();
    logic       tick, wr, rd;
    logic [2:0] off;
    logic [63:0] nt, nc;
    logic [7:0] npc, ndiv;
    logic       nen;
    off  = address[4:2];
    wr   = write && model_sel();
    rd   = read && model_sel() && !write && !m_resp;
    tick = m_en && (m_pc == m_div);
    nt   = tick ? m_mtime + 64'd1 : m_mtime;
    npc  = (m_en && !tick) ? m_pc + 8'd1 : 8'd0;
    nc = m_cmp; nen = m_en; ndiv = m_div;
    if (wr) begin
      case (off)
        3'd0: nt = {m_mtime[63:32], merge(m_mtime[31:0], writedata, byteenable)};
        3'd1: nt = {merge(m_mtime[63:32], writedata, byteenable), m_mtime[31:0]};
        3'd2: nc = {m_cmp[63:32], merge(m_cmp[31:0], writedata, byteenable)};
        3'd3: nc = {merge(m_cmp[63:32], writedata, byteenable), m_cmp[31:0]};
        3'd4: begin
          if (byteenable[0]) nen = writedata[0];
          if (byteenable[1]) begin ndiv = writedata[15:8]; npc = 8'd0; end
        end
        default: ;
      endcase
    end
    if (rd) begin
      m_rdata = reg_value(off);
      if (off == 3'd0) m_shadow = m_mtime[63:32];
    end
    m_irq = m_en && (m_mtime >= m_cmp);
    m_resp = rd; m_mtime = nt; m_cmp = nc; m_en = nen; m_div = ndiv; m_pc = npc;
  endtask

  // Called at a negedge with inputs driven; checks outputs, then advances one clock.
  task automatic step();
    #1;
    check("waitrequest", waitrequest, read && model_sel() && !write && !m_resp);
    check("readdata", readdata, m_resp ? m_rdata : 32'h0);
    check("irq", irq, m_irq);
    @(posedge clk);
    model_update();
    @(negedge clk);
  endtask

  task automatic wr(input logic [2:0] off, input logic [31:0] d, input logic [3:0] be);
    address = BASE | {27'h0, off, 2'b00}; write = 1'b1; writedata = d; byteenable = be;
    step();
    write = 1'b0; byteenable = 4'h0;
  endtask

  task automatic rd(input logic [2:0] off, output logic [31:0] d);
    address = BASE | {27'h0, off, 2'b00}; read = 1'b1;
    #1 check("rd_wait_req", waitrequest, 1'b1);
    step();
    read = 1'b0;
    #1 check("rd_wait_resp", waitrequest, 1'b0);
    d = readdata;
    step();
  endtask

  initial begin
    logic [31:0] v;
    logic        seen;
    reset_n = 1'b0; address = 32'h0; write = 1'b0; writedata = 32'h0;
    byteenable = 4'h0; read = 1'b0;
    model_reset();
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    step();

    rd(3'd3, v); check("cmpHi_reset", v, 32'hFFFF_FFFF);
    check("irq_reset", irq, 1'b0);

    wr(3'd4, 32'h0000_0301, 4'hF);
    repeat (40) step();
    rd(3'd0, v);
    check("div3_lo_range", (v >= 32'd9 && v <= 32'd11), 1'b1);

    wr(3'd4, 32'h0, 4'hF);
    wr(3'd0, 32'hFFFF_FFFF, 4'hF); wr(3'd1, 32'h0, 4'hF);
    wr(3'd4, 32'h1, 4'hF); wr(3'd4, 32'h0, 4'hF);
    rd(3'd0, v); check("carry_lo", v, 32'h0);
    rd(3'd1, v); check("carry_hi", v, 32'h1);
    wr(3'd0, 32'hFFFF_FFFF, 4'hF); wr(3'd1, 32'hFFFF_FFFF, 4'hF);
    wr(3'd4, 32'h1, 4'hF); wr(3'd4, 32'h0, 4'hF);
    rd(3'd0, v); check("wrap_lo", v, 32'h0);
    rd(3'd1, v); check("wrap_hi", v, 32'h0);

    wr(3'd0, 32'hFFFF_FFFF, 4'hF); wr(3'd1, 32'h1, 4'hF);
    wr(3'd4, 32'h1, 4'hF);
    rd(3'd0, v); check("shadow_lo", v, 32'hFFFF_FFFF);
    rd(3'd1, v); check("shadow_hi", v, 32'h1);
    wr(3'd4, 32'h0, 4'hF);

    wr(3'd0, 32'h0, 4'hF); wr(3'd1, 32'h0, 4'hF);
    wr(3'd3, 32'h0, 4'hF); wr(3'd2, 32'd20, 4'hF);
    wr(3'd4, 32'h1, 4'hF);
    seen = 1'b0;
    for (int i = 0; i < 60 && !seen; i++) begin
      step();
      seen = irq;
    end
    check("irq_rise_seen", seen, 1'b1);
    wr(3'd2, 32'h0000_FFFF, 4'hF);
    step();
    #1 check("irq_fall", irq, 1'b0);

    address = BASE; read = 1'b1;
    step();
    #2 reset_n = 1'b0;
    #1 check("rst_wait", waitrequest, 1'b0);
    check("rst_rdata", readdata, 32'h0);
    read = 1'b0;
    @(posedge clk); @(negedge clk);
    reset_n = 1'b1;
    model_reset();
    rd(3'd0, v); check("rst_mtime_lo", v, 32'h0);
    rd(3'd1, v); check("rst_mtime_hi", v, 32'h0);
    rd(3'd2, v); check("rst_cmp_lo", v, 32'hFFFF_FFFF);
    rd(3'd3, v); check("rst_cmp_hi", v, 32'hFFFF_FFFF);
    rd(3'd4, v); check("rst_ctrl", v, 32'h0);
    wr(3'd4, 32'h0000_0501, 4'b0010);
    rd(3'd4, v); check("ctrl_be_div", v, 32'h0000_0500);

    for (int i = 0; i < 400; i++) begin
      logic [2:0]  off;
      logic [31:0] d;
      off = 3'($urandom_range(0, 7));
      d = $urandom;
      if (off == 3'd4) d[15:8] = 8'($urandom_range(0, 3));
      address    = (($urandom % 8) == 0) ? (32'h1000_0000 | {27'h0, off, 2'b00})
                                         : (BASE | {27'h0, off, 2'b00});
      write      = (($urandom % 4) == 0);
      read       = (($urandom % 2) == 0);
      writedata  = d;
      byteenable = 4'($urandom);
      step();
    end
    write = 1'b0; read = 1'b0;
    step();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/rv32i_timer.md
# rv32i_timer

Memory-mapped machine timer for the RV32I soft processor, sitting directly downstream of the core's data bus (daddress/dwrite/dwritedata/dbyteenable/dread/dreaddata/dwaitrequest) and feeding the core's `irq` input. Provides a 64-bit free-running `mtime` counter with programmable prescale, a 64-bit `mtimecmp` compare register and a level interrupt. Reads take one wait state; writes complete with zero wait states.

## Interface
Parameters:
- `RV32I_TIMER_BASE`, 32'hF0000000, byte base address; block decodes `address[31:5] == RV32I_TIMER_BASE[31:5]`.
- `RV32I_TIMER_DIV_RESET`, 8'd0, reset value of the CTRL.DIV field.

Ports (clk and reset_n: one clock; reset is asynchronous and active-low):
- `clk` input 1: system clock.
- `reset_n` input 1: asynchronous active-low reset.
- `address` input 32: byte address from core `daddress`.
- `write` input 1: write strobe from `dwrite`.
- `writedata` input 32: write data from `dwritedata`.
- `byteenable` input 4: byte lanes for writes from `dbyteenable`.
- `read` input 1: read strobe from `dread`.
- `readdata` output 32: read data, valid only in the read completion cycle, else 0.
- `waitrequest` output 1: stall for reads, to `dwaitrequest`.
- `irq` output 1: timer interrupt, to core `irq`.

## Operation
- Register map (offset = address[4:2]): 0 MTIME_LO, 1 MTIME_HI, 2 MTIMECMP_LO, 3 MTIMECMP_HI, 4 CTRL (bit0 EN, bits[15:8] DIV), others read 0, writes ignored.
- Reset values: mtime 0, mtimecmp 64'hFFFFFFFF_FFFFFFFF, CTRL EN=0 DIV=`RV32I_TIMER_DIV_RESET`, prescale count 0, shadow 0, FSM IDLE, `readdata` 0, `waitrequest` 0, `irq` 0.
- Prescaler: when EN=1, 8-bit counter counts 0..DIV; a tick fires when count==DIV, then count reloads 0. DIV=0 ticks every cycle. EN=0 holds counter and clears prescale count.
- On tick, mtime increments by 1 (64-bit, wraps FFFF..FF -> 0).
- Writes: any byte lane subset honoured per `byteenable`. A write to MTIME_LO or MTIME_HI in a tick cycle: written value wins, no increment that cycle (for both halves). Write to CTRL.DIV resets prescale count to 0.
- Atomic 64-bit read: reading MTIME_LO captures mtime[63:32] into a shadow; reading MTIME_HI returns the shadow, not live mtime. MTIMECMP reads are direct.
- Read FSM: IDLE -> (read & selected & !write) capture data into readdata register, assert waitrequest -> RESP. RESP: waitrequest 0, readdata valid -> IDLE unconditionally. Read still high in IDLE after RESP starts a new access.
- Unselected address: waitrequest 0, readdata 0, writes ignored. Simultaneous read & write (illegal from core): write performed, read ignored.
- irq = registered (EN & mtime >= mtimecmp), unsigned 64-bit compare, level-sensitive; cleared by raising mtimecmp or clearing EN.

## Timing
- Read latency: request cycle N sees waitrequest=1; cycle N+1 waitrequest=0, readdata valid; value is the register contents at cycle N (pre-increment if tick in N).
- Write: single cycle, effect visible in register from N+1.
- irq: updates one cycle after mtime/mtimecmp/EN change.
- Async reset mid-read: FSM to IDLE, waitrequest and readdata to 0 immediately; core must reissue.

## Structure
- Shared package/header `rv32i_timer_pkg`: register offset constants, CTRL bit positions, FSM state encodings (IDLE, RESP).
- One sub-module: `rv32i_timer_prescaler` (EN, DIV, div-write clear -> tick). Register file, compare and bus FSM stay in the top.

## Test plan
- Reset, then read MTIMECMP_HI -> 1 wait cycle, readdata 32'hFFFFFFFF; irq 0.
- CTRL=0x0000_0301 (EN, DIV=3) -> mtime increments every 4 clocks; after 40 clocks MTIME_LO reads 10 (±1 for read timing).
- MTIME_LO/HI written 32'hFFFFFFFF/32'h0000_0000, DIV=0 -> next tick MTIME_HI=1, LO=0; then set to all-ones and verify wrap to 0.
- mtimecmp=20, EN, DIV=0 -> irq rises cycle after mtime reaches 20; write MTIMECMP_LO=0xFFFF -> irq falls next cycle.
- Read MTIME_LO when mtime=0x1_FFFFFFFF, tick carries, then read MTIME_HI -> returns 1 (shadow), not 2.
- Assert reset_n low during RESP -> waitrequest/readdata 0 immediately, all registers at reset values; byteenable=4'b0010 write to CTRL changes DIV bits [15:8] only.
